regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-side master for the 32x32 register file write port (rf_we/rf_wa/rf_wd).
//  Merges two result sources: single-cycle ALU (priority, no backpressure) and
//  long-latency unit (MUL/DIV/LOAD, valid/ready) buffered in a FIFO. Drives one
//  registered write per cycle and exports a pending-write mask for issue-stage hazard stalls.
// PARAMETERS
//  DEPTH     4   long-latency FIFO entries; power of 2, >=2
//  MAX_WAIT  8   consecutive cycles the FIFO head may be denied before ALU is stalled; >=1
//  DATA_W    32  write data width
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  alu_we      in   1       ALU result valid this cycle
//  alu_wa      in   5       ALU destination register
//  alu_wd      in   DATA_W  ALU result
//  alu_stall   out  1       ALU write slot taken by FIFO this cycle; upstream must hold
//  lu_valid    in   1       long-latency result valid
//  lu_ready    out  1       FIFO can accept (= !full)
//  lu_wa       in   5       long-latency destination register
//  lu_wd       in   DATA_W  long-latency result
//  rf_we       out  1       register file write enable (registered)
//  rf_wa       out  5       register file write address (registered)
//  rf_wd       out  DATA_W  register file write data (registered)
//  fifo_count  out  clog2(DEPTH+1)  occupied FIFO entries
//  pending     out  32      bit i = a buffered or in-flight write targets register i
// BEHAVIOUR
//  - Reset (reset=0, async): rf_we=0, rf_wa=0, rf_wd=0, fifo_count=0, pending=0,
//    alu_stall=0, starve counter=0; lu_ready=1 once reset released. FIFO contents discarded.
//  - Each rising edge selects the output register's next write:
//    1) alu_stall=1 and FIFO non-empty: pop head to rf_*; ALU input ignored.
//    2) else alu_we=1 and alu_wa!=0: load ALU write.
//    3) else FIFO non-empty: pop head.
//    4) else rf_we<=0 (rf_wa/rf_wd hold).
//  - ALU latency: sampled at edge N -> rf_we=1 in the cycle after edge N.
//  - alu_we with alu_wa=0: no write, slot free for FIFO.
//  - LU handshake: transfer on lu_valid&&lu_ready at edge N; push at N; earliest
//    rf_we for it is the cycle after edge N+1 (2-cycle min latency). lu_valid may not
//    drop or change lu_wa/lu_wd until transfer. lu_ready=(fifo_count<DEPTH), from
//    registered count only (no same-cycle pop credit).
//  - lu_wa=0: handshake completes, entry discarded (no push, no count change).
//  - Push+pop same edge: count unchanged, FIFO order preserved; pointers wrap mod DEPTH.
//  - Starvation: counter +1 each edge FIFO is non-empty and not popped; cleared on pop
//    or when empty. alu_stall is registered, =1 for exactly one cycle after counter
//    reaches MAX_WAIT; that cycle FIFO wins (rule 1) and counter clears.
//  - pending[i]=1 iff any valid FIFO entry has wa=i, or rf_we=1 and rf_wa=i;
//    pending[0]=0 always. Issue stage stalls reads and ALU writes to pending registers;
//    the arbiter does not reorder or check WAW.
//  - Reset mid-operation: buffered results lost; no rf_we after reset release until new inputs.
// TESTING
//  1. reset=0 two cycles, inputs random -> rf_we=0, rf_wa=0, rf_wd=0, fifo_count=0,
//     pending=0, alu_stall=0; after release lu_ready=1.
//  2. alu_we=1 alu_wa=5 alu_wd=32'hDEADBEEF at edge N -> next cycle rf_we=1,
//     rf_wa=5, rf_wd=32'hDEADBEEF; alu_wa=0 at edge N+1 -> rf_we=0.
//  3. alu_we=1 every cycle (wa=1..), push LU wa=7,8,9,10 -> fifo_count=4, lu_ready=0,
//     pending bits 7..10 =1; 5th lu_valid held until a pop.
//  4. MAX_WAIT=8, alu_we=1 every cycle, one LU entry wa=3 wd=32'h12345678 ->
//     alu_stall=1 exactly one cycle, 8 cycles after push; then rf_wa=3, rf_wd=32'h12345678.
//  5. 3 entries buffered, pulse reset=0 mid-cycle -> immediately fifo_count=0,
//     pending=0, rf_we=0; no writes of old entries after release.
//  6. LU push wa=0 wd=32'hFFFFFFFF with FIFO empty, alu_we=0 -> handshake completes,
//     fifo_count stays 0, rf_we stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the write-back arbiter's source-side and register-file-side signals.
// slave = the arbiter, master = whatever drives the ALU/LU results and consumes rf_*.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  // alu_*: no backpressure except alu_stall, which asks upstream to hold its write for one cycle.
  // lu_*: a transfer happens on a rising edge where lu_valid && lu_ready;
  // lu_valid, lu_wa and lu_wd stay stable until then.
  logic                       alu_we;
  logic [4:0]                 alu_wa;
  logic [DATA_W-1:0]          alu_wd;
  logic                       alu_stall;
  logic                       lu_valid;
  logic                       lu_ready;
  logic [4:0]                 lu_wa;
  logic [DATA_W-1:0]          lu_wd;
  logic                       rf_we;
  logic [4:0]                 rf_wa;
  logic [DATA_W-1:0]          rf_wd;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [31:0]                pending;

  modport slave (
    input  alu_we, alu_wa, alu_wd, lu_valid, lu_wa, lu_wd,
    output alu_stall, lu_ready, rf_we, rf_wa, rf_wd, fifo_count, pending
  );

  modport master (
    output alu_we, alu_wa, alu_wd, lu_valid, lu_wa, lu_wd,
    input  alu_stall, lu_ready, rf_we, rf_wa, rf_wd, fifo_count, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port master: ALU results have priority, long-latency results
// queue in a FIFO, and a starvation counter occasionally steals the ALU slot.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DATA_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_wb_arbiter_if.slave      bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);

  logic [4:0]        mem_wa [DEPTH];
  logic [DATA_W-1:0] mem_wd [DEPTH];
  logic [DEPTH-1:0]  slot_valid, slot_valid_next;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve, starve_next;
  logic              alu_stall_q;
  logic              rf_we_q;
  logic [4:0]        rf_wa_q;
  logic [DATA_W-1:0] rf_wd_q;

  logic fifo_empty, lu_ready_c, push, pop, alu_take, load_alu;
  logic [31:0] pend;

  always_comb begin
    fifo_empty = (count == '0);
    lu_ready_c = (count < DEPTH_C);
    // wa=0 results complete the handshake but are never stored.
    push       = bus.lu_valid && lu_ready_c && (bus.lu_wa != 5'd0);
    alu_take   = bus.alu_we && (bus.alu_wa != 5'd0);
    pop        = !fifo_empty && (alu_stall_q || !alu_take);
    load_alu   = alu_take && !pop;

    starve_next = starve;
    if (fifo_empty || pop)
      starve_next = '0;
    else if (starve != MAX_WAIT_C)
      starve_next = starve + SW'(1);

    slot_valid_next = slot_valid;
    if (pop)
      slot_valid_next[rd_ptr] = 1'b0;
    if (push)
      slot_valid_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wa[wr_ptr] <= bus.lu_wa;
      mem_wd[wr_ptr] <= bus.lu_wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      slot_valid  <= '0;
      starve      <= '0;
      alu_stall_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count       <= count + CW'(push) - CW'(pop);
      slot_valid  <= slot_valid_next;
      starve      <= starve_next;
      alu_stall_q <= (starve_next == MAX_WAIT_C);
      if (pop) begin
        rf_we_q <= 1'b1;
        rf_wa_q <= mem_wa[rd_ptr];
        rf_wd_q <= mem_wd[rd_ptr];
      end else if (load_alu) begin
        rf_we_q <= 1'b1;
        rf_wa_q <= bus.alu_wa;
        rf_wd_q <= bus.alu_wd;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  // Hazard mask covers every buffered entry plus the write currently on the port.
  always_comb begin
    pend = '0;
    for (int j = 0; j < DEPTH; j++)
      if (slot_valid[j])
        pend[mem_wa[j]] = 1'b1;
    if (rf_we_q)
      pend[rf_wa_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.lu_ready   = lu_ready_c;
  assign bus.alu_stall  = alu_stall_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_wa      = rf_wa_q;
  assign bus.rf_wd      = rf_wd_q;
  assign bus.fifo_count = count;
  assign bus.pending    = pend;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU path, LU FIFO fill/drain,
// starvation stall, mid-operation reset and wa=0 discard.
module tb_regfile_wb_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  regfile_wb_arbiter_if #(.DEPTH(4), .DATA_W(32)) bus ();

  regfile_wb_arbiter #(.DEPTH(4), .MAX_WAIT(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alu_we   = 1'b0;
    bus.alu_wa   = '0;
    bus.alu_wd   = '0;
    bus.lu_valid = 1'b0;
    bus.lu_wa    = '0;
    bus.lu_wd    = '0;
  endtask

  task automatic rand_inputs();
    bus.alu_we   = 1'($urandom_range(0, 1));
    bus.alu_wa   = 5'($urandom_range(0, 31));
    bus.alu_wd   = $urandom;
    bus.lu_valid = 1'($urandom_range(0, 1));
    bus.lu_wa    = 5'($urandom_range(0, 31));
    bus.lu_wd    = $urandom;
  endtask

  int exp_cnt [11] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 3, 4};
  int exp_wa  [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 7, 10};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    rand_inputs();

    // reset with random inputs
    repeat (2) begin
      @(negedge clk);
      rand_inputs();
    end
    check("rst_rf_we",     32'(bus.rf_we), 32'd0);
    check("rst_rf_wa",     32'(bus.rf_wa), 32'd0);
    check("rst_rf_wd",     bus.rf_wd, 32'd0);
    check("rst_count",     32'(bus.fifo_count), 32'd0);
    check("rst_pending",   bus.pending, 32'd0);
    check("rst_alu_stall", 32'(bus.alu_stall), 32'd0);
    idle_inputs();
    reset = 1'b1;
    tick();
    check("rel_lu_ready", 32'(bus.lu_ready), 32'd1);
    check("rel_rf_we",    32'(bus.rf_we), 32'd0);

    // single ALU write, then alu_wa=0 gives no write
    bus.alu_we = 1'b1;
    bus.alu_wa = 5'd5;
    bus.alu_wd = 32'hDEADBEEF;
    tick();
    check("alu_rf_we",   32'(bus.rf_we), 32'd1);
    check("alu_rf_wa",   32'(bus.rf_wa), 32'd5);
    check("alu_rf_wd",   bus.rf_wd, 32'hDEADBEEF);
    check("alu_pending", bus.pending, 32'h0000_0020);
    bus.alu_wa = 5'd0;
    bus.alu_wd = 32'h1111_1111;
    tick();
    check("alu0_rf_we",   32'(bus.rf_we), 32'd0);
    check("alu0_rf_wa",   32'(bus.rf_wa), 32'd5);
    check("alu0_pending", bus.pending, 32'd0);
    idle_inputs();

    // LU result to r0 is accepted and dropped
    bus.lu_valid = 1'b1;
    bus.lu_wa    = 5'd0;
    bus.lu_wd    = 32'hFFFFFFFF;
    check("lu0_ready", 32'(bus.lu_ready), 32'd1);
    tick();
    bus.lu_valid = 1'b0;
    check("lu0_count", 32'(bus.fifo_count), 32'd0);
    check("lu0_rf_we", 32'(bus.rf_we), 32'd0);
    tick();
    check("lu0_rf_we2", 32'(bus.rf_we), 32'd0);

    // ALU every cycle while LU fills the FIFO; 5th LU result waits for a pop
    for (int k = 1; k <= 11; k++) begin
      bus.alu_we   = 1'b1;
      bus.alu_wa   = 5'((k <= 9) ? k : 10);
      bus.alu_wd   = 32'h100 + 32'(k);
      bus.lu_valid = 1'b1;
      if (k <= 4) begin
        bus.lu_wa = 5'(6 + k);
        bus.lu_wd = 32'((6 + k) * 16);
      end else begin
        bus.lu_wa = 5'd11;
        bus.lu_wd = 32'hB0;
      end
      tick();
      check($sformatf("fill_count_%0d", k), 32'(bus.fifo_count), 32'(exp_cnt[k-1]));
      check($sformatf("fill_ready_%0d", k), 32'(bus.lu_ready), (exp_cnt[k-1] < 4) ? 32'd1 : 32'd0);
      check($sformatf("fill_stall_%0d", k), 32'(bus.alu_stall), (k == 9) ? 32'd1 : 32'd0);
      check($sformatf("fill_rf_wa_%0d", k), 32'(bus.rf_wa), 32'(exp_wa[k-1]));
      if (k == 4)
        check("fill_pending_full", bus.pending, 32'h0000_0790);
      if (k == 10)
        check("fill_pop_rf_wd", bus.rf_wd, 32'h70);
    end
    check("fill_pending_end", bus.pending, 32'h0000_0F00);
    idle_inputs();

    // drain in order
    for (int d = 0; d < 4; d++) begin
      tick();
      check($sformatf("drain_rf_wa_%0d", d), 32'(bus.rf_wa), 32'(8 + d));
      check($sformatf("drain_rf_wd_%0d", d), bus.rf_wd, 32'((8 + d) * 16));
      check($sformatf("drain_count_%0d", d), 32'(bus.fifo_count), 32'(3 - d));
    end
    tick();
    check("drain_rf_we_idle", 32'(bus.rf_we), 32'd0);
    check("drain_pending",    bus.pending, 32'd0);

    // starvation: one entry behind a continuous ALU stream
    for (int j = 0; j <= 9; j++) begin
      bus.alu_we   = 1'b1;
      bus.alu_wa   = 5'd20;
      bus.alu_wd   = 32'h200 + 32'(j);
      bus.lu_valid = (j == 0);
      bus.lu_wa    = 5'd3;
      bus.lu_wd    = 32'h12345678;
      tick();
      check($sformatf("starve_stall_%0d", j), 32'(bus.alu_stall), (j == 8) ? 32'd1 : 32'd0);
    end
    check("starve_rf_wa",  32'(bus.rf_wa), 32'd3);
    check("starve_rf_wd",  bus.rf_wd, 32'h12345678);
    check("starve_count",  32'(bus.fifo_count), 32'd0);
    tick();
    check("starve_alu_resume", 32'(bus.rf_wa), 32'd20);
    check("starve_alu_wd",     bus.rf_wd, 32'h209);

    // three buffered entries, then an asynchronous reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      bus.alu_we   = 1'b1;
      bus.alu_wa   = 5'd20;
      bus.lu_valid = 1'b1;
      bus.lu_wa    = 5'(12 + k);
      bus.lu_wd    = 32'h300 + 32'(k);
      tick();
      check($sformatf("pre_rst_count_%0d", k), 32'(bus.fifo_count), 32'(k + 1));
    end
    bus.lu_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_count",   32'(bus.fifo_count), 32'd0);
    check("mid_rst_pending", bus.pending, 32'd0);
    check("mid_rst_rf_we",   32'(bus.rf_we), 32'd0);
    check("mid_rst_stall",   32'(bus.alu_stall), 32'd0);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("post_rst_rf_we_%0d", k), 32'(bus.rf_we), 32'd0);
      check($sformatf("post_rst_count_%0d", k), 32'(bus.fifo_count), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
